pattern_stream_ctrl: RTL and testbench
======================================

# pattern_stream_ctrl

Word-level controller for the overlapping "0101" serial pattern detector. It accepts parallel words over a valid/ready handshake and feeds them MSB-first, one bit per clock, into an embedded Moore 0101 detector. It reports the number of pattern matches per word and keeps a saturating running total. It sits between a word-oriented producer and the bit-serial detection datapath, and it owns the detector's sequencing and history clearing.

## Interface
- WORD_W, 8: bits per input word; legal range ≥ 2.
- CNT_W, 16: width of the saturating running total.
- CW (localparam), $clog2(WORD_W)+1: width of the per-word match count.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  input  1  in_data is valid.
- in_data  input  WORD_W  word to scan; bit WORD_W-1 is fed first.
- in_ready  output  1  controller can accept a word (high only in IDLE).
- flush  input  1  clear detector history; sampled only in IDLE.
- out_valid  output  1  out_count holds a finished word's result.
- out_count  output  CW  matches completed while this word's bits were fed.
- out_ready  input  1  consumer accepts the result.
- total_count  output  CNT_W  saturating sum of all matches since reset.
- busy  output  1  high in SHIFT or DONE.

## Operation
- Controller FSM has three states:
  - IDLE: in_ready=1. On in_valid: load the shift register, clear bit_idx and out_count, go to SHIFT.
  - SHIFT: each cycle, feed shreg[WORD_W-1] to the detector, shift left, increment bit_idx. After the WORD_W-th bit, go to DONE.
  - DONE: out_valid=1; out_count is held stable. When out_ready is high, go to IDLE.
- Embedded detector FSM has states D_IDLE, D_0, D_01, D_010, D_0101. It follows the 0101 transitions with overlap:
  - On 0, D_0101 goes to D_010.
  - On 1, D_0101 goes to D_IDLE.
  - The detector state advances only in SHIFT cycles.
- Match rule: a match is counted in the cycle where the fed bit drives the detector's next state to D_0101. On a match, out_count +1 and total_count +1 in the same edge.
- total_count saturates at all-ones and never wraps.
- Detector history persists across words, so a pattern may span a word boundary. The match is credited to the word that supplies the final "1".
- flush in IDLE sets the detector to D_IDLE. flush in SHIFT or DONE is ignored.
- flush and in_valid in the same IDLE cycle: the word is accepted and starts from D_IDLE history.
- Reset:
  - FSM → IDLE, detector → D_IDLE, shift register and bit_idx cleared.
  - out_count=0, total_count=0, out_valid=0, busy=0, in_ready=1 from the first cycle after reset.
  - A reset in SHIFT or DONE aborts the word; its result is discarded.
  - reset has priority over every other input.

## Timing
- Accept edge E0 is the edge where in_valid && in_ready.
- Bits are consumed at edges E1..E_WORD_W.
- out_valid is high from after E_WORD_W, i.e. WORD_W cycles after acceptance.
- The result handshake completes at the edge where out_valid && out_ready. in_ready is high in the following cycle.
- A new word cannot be accepted in the same cycle as the result handshake.
- Throughput with out_ready tied high: one word per WORD_W+2 cycles.
- While out_ready is low, out_valid, out_count and total_count are held unchanged and in_ready stays 0.
- in_ready, out_valid and busy are decoded from the state register only; there is no combinational path from inputs.
- out_count and total_count are registered.

## Test plan
- After reset, send 8'b0101_0101 → out_valid 8 cycles after acceptance, out_count=3, total_count=3.
- Without flush, follow with 8'b0100_0000 → out_count=1 (carried-over history D_0101), total_count=4. Then 8'hFF → out_count=0.
- Cross-boundary with flush:
  - 8'b0000_0010 then 8'b1000_0000 → counts 0 then 1.
  - Repeat after reset with flush pulsed in IDLE between the words → counts 0 then 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_count stable, in_ready=0, in_valid ignored. Raise out_ready → IDLE next cycle.
- Saturation with CNT_W=2: send 8'h55 twice → total_count=3 (not 6), out_count=3 each time.
- Assert reset at the 4th SHIFT cycle of 8'h55 → next cycle in_ready=1, out_valid=0, total_count=0. A fresh 8'h55 then gives out_count=3.

Source files
------------

// File: rtl/pattern_stream_ctrl.sv
// Word-to-bit controller around an overlapping "0101" Moore detector.
// Feeds each accepted word MSB-first, counts matches per word and a saturating total.
module pattern_stream_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16,
  localparam int CW    = $clog2(WORD_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [CW-1:0]     out_count,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  total_count,
  output logic              busy
);

  localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [2:0] {D_IDLE, D_0, D_01, D_010, D_0101} det_e;

  state_e             state_q, state_d;
  det_e               det_q, det_d, det_step;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]      bit_idx_q, bit_idx_d;
  logic [CW-1:0]      out_count_q, out_count_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic               bit_in;

  assign bit_in = shreg_q[WORD_W-1];

  // Overlapping transitions: after a full match, a 0 still leaves "010" as a valid prefix.
  always_comb begin
    det_step = D_IDLE;
    case (det_q)
      D_IDLE:  det_step = bit_in ? D_IDLE : D_0;
      D_0:     det_step = bit_in ? D_01   : D_0;
      D_01:    det_step = bit_in ? D_IDLE : D_010;
      D_010:   det_step = bit_in ? D_0101 : D_0;
      D_0101:  det_step = bit_in ? D_IDLE : D_010;
      default: det_step = D_IDLE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    det_d       = det_q;
    shreg_d     = shreg_q;
    bit_idx_d   = bit_idx_q;
    out_count_d = out_count_q;
    total_d     = total_q;
    case (state_q)
      S_IDLE: begin
        if (flush) det_d = D_IDLE;
        if (in_valid) begin
          shreg_d     = in_data;
          bit_idx_d   = '0;
          out_count_d = '0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        det_d     = det_step;
        shreg_d   = shreg_q << 1;
        bit_idx_d = bit_idx_q + BW'(1);
        if (det_step == D_0101) begin
          out_count_d = out_count_q + CW'(1);
          if (total_q != '1) total_d = total_q + CNT_W'(1);
        end
        if (bit_idx_q == BW'(WORD_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      det_q       <= D_IDLE;
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      out_count_q <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      shreg_q     <= shreg_d;
      bit_idx_q   <= bit_idx_d;
      out_count_q <= out_count_d;
      total_q     <= total_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign out_count   = out_count_q;
  assign total_count = total_q;

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Self-checking bench: directed table, corner sequences and random words vs a sliding-window model.
// A second instance with a 2-bit total shares all stimulus to exercise saturation.
module tb_pattern_stream_ctrl;
  localparam int WORD_W = 8;
  localparam int CW     = $clog2(WORD_W) + 1;

  logic              clk = 0;
  logic              reset = 0;
  logic              in_valid = 0;
  logic [WORD_W-1:0] in_data = '0;
  logic              flush = 0;
  logic              out_ready = 0;
  logic              in_ready, out_valid, busy;
  logic [CW-1:0]     out_count;
  logic [15:0]       total_count;
  logic              s_in_ready, s_out_valid, s_busy;
  logic [CW-1:0]     s_out_count;
  logic [1:0]        s_total_count;

  int checks = 0;
  int errors = 0;

  // Reference model: last four bits fed since the most recent clear.
  logic [3:0] hist;
  int         nvalid;
  int         model_cnt;
  int         model_total;

  always #5 clk = ~clk;

  pattern_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_count(out_count), .out_ready(out_ready),
    .total_count(total_count), .busy(busy)
  );

  pattern_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .flush(flush), .out_valid(s_out_valid),
    .out_count(s_out_count), .out_ready(out_ready),
    .total_count(s_total_count), .busy(s_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_clear();
    hist   = 4'b0;
    nvalid = 0;
  endtask

  task automatic model_word(input logic [WORD_W-1:0] w, input bit fl);
    if (fl) model_clear();
    model_cnt = 0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      hist = {hist[2:0], w[i]};
      nvalid++;
      if (nvalid >= 4 && hist == 4'b0101) model_cnt++;
    end
    model_total += model_cnt;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    model_total = 0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_total", int'(total_count), 0);
  endtask

  task automatic pulse_flush();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    model_clear();
  endtask

  // Caller is always #1 after a rising edge with the DUT in IDLE.
  task automatic send_word(input logic [WORD_W-1:0] w, input bit fl, input int stall,
                           input bit poke, input bit shift_noise, output int got);
    int k;
    int held;
    int held_total;
    check("in_ready_before", int'(in_ready), 1);
    in_valid = 1; in_data = w; flush = fl;
    @(posedge clk); #1;
    in_valid = 0; flush = 0; in_data = WORD_W'($urandom);
    model_word(w, fl);
    k = 0;
    while (!out_valid && k < 40) begin
      if (shift_noise) flush = 1'($urandom);
      @(posedge clk); #1;
      k++;
    end
    flush = 0;
    check("latency", k, WORD_W);
    check("out_count", int'(out_count), model_cnt);
    check("total", int'(total_count), model_total);
    check("sat_total", int'(s_total_count), sat3(model_total));
    check("done_in_ready", int'(in_ready), 0);
    check("done_busy", int'(busy), 1);
    got = int'(out_count);
    held = int'(out_count);
    held_total = int'(total_count);
    for (int s = 0; s < stall; s++) begin
      if (poke) begin in_valid = 1; in_data = ~w; end
      @(posedge clk); #1;
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_count", int'(out_count), held);
      check("stall_total", int'(total_count), held_total);
      check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("post_hs_in_ready", int'(in_ready), 1);
    check("post_hs_out_valid", int'(out_valid), 0);
  endtask

  typedef struct {
    bit                rst;
    bit                fl;
    logic [WORD_W-1:0] word;
    int                exp_count;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int got;
    model_clear();
    model_total = 0;
    model_cnt = 0;

    vecs[0] = '{1'b1, 1'b0, 8'b0101_0101, 3};
    vecs[1] = '{1'b0, 1'b0, 8'b0100_0000, 1};
    vecs[2] = '{1'b0, 1'b0, 8'hFF,        0};
    vecs[3] = '{1'b1, 1'b0, 8'b0000_0010, 0};
    vecs[4] = '{1'b0, 1'b0, 8'b1000_0000, 1};
    vecs[5] = '{1'b1, 1'b0, 8'b0000_0010, 0};
    vecs[6] = '{1'b0, 1'b1, 8'b1000_0000, 0};

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].fl) pulse_flush();
      send_word(vecs[i].word, 1'b0, 0, 1'b0, 1'b0, got);
      check($sformatf("table_count[%0d]", i), got, vecs[i].exp_count);
    end

    // Backpressure with in_valid poked while the result is held.
    do_reset();
    send_word(8'h55, 1'b0, 5, 1'b1, 1'b0, got);
    check("bp_count", got, 3);

    // Saturation: flush keeps each word at 3 matches; narrow total pins at 3.
    do_reset();
    send_word(8'h55, 1'b1, 0, 1'b0, 1'b0, got);
    check("sat_first", int'(s_out_count), 3);
    send_word(8'h55, 1'b1, 0, 1'b0, 1'b0, got);
    check("sat_second", int'(s_out_count), 3);
    check("sat_pinned", int'(s_total_count), 3);
    check("wide_total", int'(total_count), 6);

    // Reset landing on the 4th bit edge aborts the word.
    in_valid = 1; in_data = 8'h55;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    do_reset();
    send_word(8'h55, 1'b0, 0, 1'b0, 1'b0, got);
    check("after_abort_count", got, 3);

    // Random words, flush mixes (with accept, standalone, ignored during shift), random stalls.
    for (int n = 0; n < 60; n++) begin
      bit standalone;
      standalone = ($urandom_range(0, 5) == 0);
      if (standalone) pulse_flush();
      send_word(WORD_W'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                1'($urandom), 1'b1, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
